if_stage_fetch: RTL and testbench
=================================

IF_STAGE_FETCH -- requirements
Module: if_stage_fetch

Interface
REQ-001 SHALL have a single clock, `clk`; reset is synchronous and active-low, on port `rst`.
REQ-002 SHALL have parameter NOP_INSTR, default 32'hE0000000, meaning the bubble instruction presented when no fetched instruction is available.
REQ-003 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-004 Ports SHALL be:
  - clk  in  1  rising-edge clock.
  - rst  in  1  synchronous, active-low reset.
  - freeze  in  1  hazard stall; downstream IF register is holding.
  - branch_taken  in  1  redirect from EXE; valid regardless of freeze.
  - branch_addr  in  32  redirect target.
  - imem_req  out  1  fetch request.
  - imem_addr  out  32  fetch address.
  - imem_gnt  in  1  memory accepts the request this cycle.
  - imem_rvalid  in  1  read data valid.
  - imem_rdata  in  32  fetched instruction.
  - pc  out  32  address of the presented instruction, plus 4.
  - instruction  out  32  presented instruction.
  - valid  out  1  presented instruction is real, not a bubble.

Function
REQ-005 SHALL keep a fetch_pc register, a req_pc register, a 2-entry FIFO of {pc+4, instr}, and a 3-state FSM: IDLE (no request outstanding), WAIT (live request outstanding), DROP (stale request outstanding).
REQ-006 SHALL allow at most one outstanding memory transaction.
REQ-007 imem_req SHALL be 1 iff state==IDLE, FIFO count<2, and branch_taken==0; imem_addr SHALL equal fetch_pc.
REQ-008 On a cycle where imem_req and imem_gnt are both 1, the block SHALL:
  - set req_pc to fetch_pc;
  - set fetch_pc to fetch_pc+4 (modulo 2^32, wrapping from 32'hFFFFFFFC to 0);
  - move to WAIT.
REQ-009 While imem_req is 1 and imem_gnt is 0, the block SHALL hold imem_req and imem_addr stable.
REQ-010 In WAIT, on imem_rvalid with branch_taken==0, the block SHALL push {req_pc+4, imem_rdata} into the FIFO and go to IDLE.
REQ-011 In DROP, on imem_rvalid, the block SHALL discard the data and go to IDLE.
REQ-012 imem_rvalid SHALL be ignored in IDLE; imem_rvalid arrives no earlier than one cycle after the grant.
REQ-013 On branch_taken==1, the block SHALL:
  - set fetch_pc to branch_addr;
  - empty the FIFO;
  - go WAIT->DROP;
  - stay in DROP if already in DROP;
  - stay in IDLE if in IDLE, with no request issued that cycle.
REQ-014 On branch_taken==1 coincident with imem_rvalid in WAIT, the block SHALL discard the data and go to IDLE.
REQ-015 The presented outputs SHALL depend on the FIFO count:
  - count>0: pc, instruction and valid SHALL show the FIFO head, with valid=1;
  - count==0: pc=0, instruction=NOP_INSTR, valid=0.
  Outputs are combinational from the FIFO head.
REQ-016 The FIFO head SHALL be popped when freeze==0, count>0 and branch_taken==0; while freeze==1 the head SHALL be held unchanged.
REQ-017 Simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-018 A push SHALL never occur when count==2, because issue requires count<2 and count does not rise while a request is outstanding; the bench checks this with an assertion.
REQ-019 Branch SHALL have priority over freeze, push and pop.

Reset
REQ-020 While rst==0 at a rising edge, the block SHALL:
  - set fetch_pc=RESET_PC, req_pc=0;
  - set FIFO count=0, state=IDLE;
  - drive imem_req=0, pc=0, instruction=NOP_INSTR, valid=0 in the following cycle.
REQ-021 Reset mid-transaction SHALL abandon the outstanding request; any imem_rvalid arriving after reset in IDLE SHALL be ignored.
REQ-022 The first request after release SHALL use address RESET_PC.

Verification
REQ-023 Reset release, then zero-wait memory that grants immediately and returns data 1 cycle later with rdata=addr|32'hE1A00000 -> imem_addr sequence is 0,4,8,...; outputs pc=4,8,12,... with valid=1, in order.
REQ-024 freeze=1 held for 5 cycles with FIFO filling -> at most 2 requests complete; head unchanged (pc=4); imem_req=0 once count==2; after release, no instruction is lost or duplicated.
REQ-025 branch_taken=1 with branch_addr=32'h100 while in WAIT, with rvalid arriving 2 cycles later -> that data is dropped; the next imem_addr is 32'h100; the next valid output has pc=32'h104.
REQ-026 branch_taken and imem_rvalid in the same WAIT cycle -> data discarded; FIFO empty; valid=0 next cycle; next request to branch_addr.
REQ-027 rst=0 asserted while a request is outstanding, then a late rvalid -> late data ignored; outputs pc=0, instruction=32'hE0000000, valid=0; first request to 0.
REQ-028 fetch_pc=32'hFFFFFFFC granted -> next imem_addr is 32'h00000000; the presented pc for that instruction is 32'h00000000.

Source files
------------

// File: rtl/if_stage_fetch_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// master = fetch stage, slave = instruction memory.
interface if_stage_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage_fetch.sv
// Fetch stage: one outstanding imem request, 2-deep
// {pc+4, instr} buffer, branch redirect with stale-response drop.
module if_stage_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'hE0000000,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  if_stage_fetch_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pc0_q, pc0_d;
  logic [31:0] pc1_q, pc1_d;
  logic [31:0] in0_q, in0_d;
  logic [31:0] in1_q, in1_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        issue;
  logic        fire;
  logic        push;
  logic        pop;
  logic [1:0]  wr_slot;

  // Handshake decode: issue, grant, response push and head pop.
  always_comb begin
    issue = rst && (state_q == S_IDLE)
         && (cnt_q != 2'd2) && !branch_taken;
    fire  = issue && imem.imem_gnt;
    push  = (state_q == S_WAIT) && imem.imem_rvalid
         && !branch_taken;
    pop   = !freeze && (cnt_q != 2'd0) && !branch_taken;
    wr_slot = cnt_q - {1'b0, pop};
  end

  assign imem.imem_req  = issue;
  assign imem.imem_addr = fetch_pc_q;

  assign valid       = (cnt_q != 2'd0);
  assign pc          = valid ? pc0_q : 32'd0;
  assign instruction = valid ? in0_q : NOP_INSTR;

  // Next-state: branch redirect wins over issue, push and pop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    in0_d      = in0_q;
    in1_d      = in1_q;
    cnt_d      = cnt_q;
    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      cnt_d      = 2'd0;
      case (state_q)
        S_WAIT:  state_d = imem.imem_rvalid ? S_IDLE : S_DROP;
        S_DROP:  state_d = imem.imem_rvalid ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_WAIT;
          end
        end
        S_WAIT:  if (imem.imem_rvalid) state_d = S_IDLE;
        S_DROP:  if (imem.imem_rvalid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (pop) begin
        pc0_d = pc1_q;
        in0_d = in1_q;
      end
      if (push) begin
        unique case (1'b1)
          (wr_slot == 2'd0): begin
            pc0_d = req_pc_q + 32'd4;
            in0_d = imem.imem_rdata;
          end
          default: begin
            pc1_d = req_pc_q + 32'd4;
            in1_d = imem.imem_rdata;
          end
        endcase
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State and buffer registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'd0;
      pc0_q      <= 32'd0;
      pc1_q      <= 32'd0;
      in0_q      <= 32'd0;
      in1_q      <= 32'd0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: random memory/stall/branch/reset
// stimulus, queue scoreboard checked by an output monitor.
module tb_if_stage_fetch;

  localparam logic [31:0] NOP = 32'hE0000000;
  localparam logic [31:0] RPC = 32'h00000000;
  localparam logic [31:0] TAG = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;

  if_stage_fetch_if bus ();

  if_stage_fetch #(
    .NOP_INSTR (NOP),
    .RESET_PC  (RPC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus),
    .pc           (pc),
    .instruction  (instruction),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  bit          wrap_seen = 0;
  logic [31:0] exp_fetch = RPC;

  int          p_gnt = 0;
  int          p_freeze = 0;
  int          p_branch = 0;
  int          p_rst = 0;
  int unsigned mind = 0;
  int unsigned maxd = 0;
  bit          hold_rst = 1;
  bit          f_rst = 0;
  bit          f_bp = 0;
  bit          f_brv = 0;
  logic [31:0] f_addr = 32'd0;

  bit          pending = 0;
  bit          stale = 0;
  logic [31:0] p_addr = 32'd0;
  int          p_cnt = 0;
  bit          cap_fire = 0;
  bit          cap_rv = 0;
  logic [31:0] cap_addr = 32'd0;
  bit          chk_inv = 0;
  bit          mon_en = 0;

  bit          prev_rst = 1;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = 32'd0;

  function automatic void chk(bit ok, string nm,
                              logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  function automatic bit roll(int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  // One clock of stimulus plus memory model and scoreboard push.
  task automatic step();
    bit exp_req;
    bit fired_brv;
    @(posedge clk);
    #1;
    if (cap_rv) pending = 0;
    else if (pending && p_cnt > 0) p_cnt--;
    if (cap_fire) begin
      pending = 1;
      p_addr  = cap_addr;
      p_cnt   = int'($urandom_range(maxd, mind));
    end
    if (!pending) stale = 0;
    rst = 1'b1;
    branch_taken = 1'b0;
    branch_addr = $urandom;
    fired_brv = 0;
    if (hold_rst) rst = 1'b0;
    else if (f_rst && pending) begin
      rst = 1'b0;
      f_rst = 0;
    end else if (roll(p_rst)) rst = 1'b0;
    if (!rst && pending) stale = 1;
    bus.imem_rvalid = pending && (p_cnt == 0);
    bus.imem_rdata  = bus.imem_rvalid ? (p_addr | TAG)
                                      : $urandom;
    bus.imem_gnt = !pending && roll(p_gnt);
    if (f_bp && pending && !bus.imem_rvalid) begin
      branch_taken = 1'b1;
      branch_addr = f_addr;
      f_bp = 0;
    end else if (f_brv && bus.imem_rvalid) begin
      branch_taken = 1'b1;
      branch_addr = f_addr;
      f_brv = 0;
      fired_brv = 1;
    end else if (roll(p_branch)) begin
      branch_taken = 1'b1;
      branch_addr = roll(50) ? 32'hFFFFFFF0
                             : ($urandom & 32'hFFFFFFFC);
    end
    freeze = roll(p_freeze);
    exp_req = rst && !branch_taken && !pending
           && (sb.size() < 2);
    @(negedge clk);
    if (!stale)
      chk(bus.imem_req == exp_req, "imem_req",
          {31'd0, bus.imem_req}, {31'd0, exp_req});
    if (chk_inv) begin
      chk(!valid, "valid_after_branch_rvalid",
          {31'd0, valid}, 32'd0);
      chk_inv = 0;
    end
    if (fired_brv) chk_inv = 1;
    cap_fire = bus.imem_req && bus.imem_gnt;
    cap_addr = bus.imem_addr;
    cap_rv   = bus.imem_rvalid;
    if (!rst) begin
      sb.delete();
      exp_fetch = RPC;
    end else if (branch_taken) begin
      sb.delete();
      exp_fetch = branch_addr;
    end else if (cap_fire) begin
      chk(cap_addr == exp_fetch, "fetch_addr",
          cap_addr, exp_fetch);
      sb.push_back('{pc: exp_fetch + 32'd4,
                     ins: exp_fetch | TAG});
      exp_fetch = exp_fetch + 32'd4;
      chk(sb.size() <= 2, "in_flight_le_2",
          sb.size(), 32'd2);
    end
  endtask

  // Output monitor: consumes scoreboard entries on every pop.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!prev_rst)
        chk(!valid && pc == 32'd0 && instruction == NOP,
            "reset_outputs", instruction, NOP);
      if (!rst)
        chk(!bus.imem_req, "req_in_reset",
            {31'd0, bus.imem_req}, 32'd0);
      if (!valid)
        chk(pc == 32'd0 && instruction == NOP,
            "bubble_outputs", pc, 32'd0);
      if (rst && branch_taken)
        chk(!bus.imem_req, "req_on_branch",
            {31'd0, bus.imem_req}, 32'd0);
      if (prev_wait && rst && !branch_taken)
        chk(bus.imem_req && bus.imem_addr == prev_addr,
            "req_hold", bus.imem_addr, prev_addr);
      if (rst && !branch_taken && !freeze && valid) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_output", pc, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk(pc == mon_e.pc, "out_pc", pc, mon_e.pc);
          chk(instruction == mon_e.ins, "out_instr",
              instruction, mon_e.ins);
          consumed++;
          if (pc == 32'd0 && instruction == (32'hFFFFFFFC | TAG))
            wrap_seen = 1;
        end
      end
    end
    prev_rst  = rst;
    prev_wait = rst && bus.imem_req && !bus.imem_gnt;
    prev_addr = bus.imem_addr;
  end

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    hold_rst = 1;
    step();
    mon_en = 1;
    step();
    step();
    hold_rst = 0;

    p_gnt = 100;
    mind = 0;
    maxd = 0;
    p_freeze = 100;
    repeat (5) step();
    chk(!bus.imem_req, "freeze_full_no_req",
        {31'd0, bus.imem_req}, 32'd0);
    chk(valid && pc == 32'd4, "freeze_head_pc",
        pc, 32'd4);
    p_freeze = 0;
    repeat (40) step();

    mind = 1;
    maxd = 1;
    f_addr = 32'h100;
    f_bp = 1;
    repeat (30) step();
    chk(!f_bp, "branch_in_wait_issued",
        {31'd0, f_bp}, 32'd0);

    mind = 0;
    maxd = 0;
    f_addr = 32'h200;
    f_brv = 1;
    repeat (30) step();
    chk(!f_brv, "branch_with_rvalid_issued",
        {31'd0, f_brv}, 32'd0);

    mind = 2;
    maxd = 3;
    f_rst = 1;
    repeat (30) step();
    chk(!f_rst, "reset_in_flight_issued",
        {31'd0, f_rst}, 32'd0);

    mind = 1;
    maxd = 1;
    f_addr = 32'hFFFFFFF8;
    f_bp = 1;
    repeat (30) step();
    chk(!f_bp, "wrap_branch_issued",
        {31'd0, f_bp}, 32'd0);
    chk(wrap_seen, "wrap_pc_zero",
        {31'd0, wrap_seen}, 32'd1);

    p_gnt = 60;
    mind = 0;
    maxd = 3;
    p_freeze = 30;
    p_branch = 3;
    p_rst = 1;
    repeat (3000) step();
    chk(consumed > 300, "progress", consumed, 32'd300);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
